// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max pooling over a serial raster stream.
// A half-width line buffer holds the top-row pair maxima until the bottom row arrives.
module maxpool_2x2_stream #(
  parameter int DATA_W   = 16,
  parameter int DIM_W    = 4,
  parameter int MAX_COLS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  feat_row,
  input  logic [DIM_W-1:0]  feat_col,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);
  localparam int LB_N  = MAX_COLS / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [DIM_W-1:0] D1 = 1;
  localparam logic [DIM_W:0]   P1 = 1;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
  state_t state;

  logic [DIM_W-1:0]  fr, fc, r, c;
  logic [DATA_W-1:0] pair;
  logic [DATA_W-1:0] linebuf [LB_N];

  logic [DIM_W:0]    prows, pcols, r_half, c_half;
  logic [LB_AW-1:0]  lb_idx;
  logic [DATA_W-1:0] pm, lb_rd, pooled;
  logic              acc, xfer, col_ok, row_ok, emit, last_in;

  // Odd trailing row/column falls out of the truncating divide.
  assign prows  = ({1'b0, fr} + P1) >> 1;
  assign pcols  = ({1'b0, fc} + P1) >> 1;
  assign r_half = {2'b0, r[DIM_W-1:1]};
  assign c_half = {2'b0, c[DIM_W-1:1]};
  assign lb_idx = LB_AW'(c >> 1);

  assign in_ready = (state == ACC) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  assign col_ok  = c[0] && (c_half < pcols);
  assign row_ok  = r[0] && (r_half < prows);
  assign pm      = (in_data > pair) ? in_data : pair;
  assign lb_rd   = linebuf[lb_idx];
  assign pooled  = (lb_rd > pm) ? lb_rd : pm;
  assign emit    = acc && col_ok && row_ok;
  assign last_in = acc && (r == fr) && (c == fc);

  always_ff @(posedge clk) begin
    if (acc && col_ok && !r[0]) linebuf[lb_idx] <= pm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fr        <= '0;
      fc        <= '0;
      r         <= '0;
      c         <= '0;
      pair      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A new result wins over a same-cycle transfer, keeping out_valid high.
      if (emit) begin
        out_data  <= pooled;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (acc) begin
        if (!c[0]) pair <= in_data;
        if (c == fc) begin
          c <= '0;
          r <= r + D1;
        end else begin
          c <= c + D1;
        end
      end
      case (state)
        IDLE: if (start) begin
          fr    <= feat_row;
          fc    <= feat_col;
          r     <= '0;
          c     <= '0;
          state <= ACC;
        end
        ACC:   if (last_in) state <= DRAIN;
        DRAIN: if (!out_valid || xfer) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
